// File: rtl/wfifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NREQ packet requesters.
// A grant is held until the owner's last beat or until MAX_BURST beats have been written.
module wfifo_wr_arb #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt, w_pick_oh;
  logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nxt, w_ptr_inc;
  logic [7:0]      r_beat_cnt, w_beat_cnt_nxt;
  logic            w_release;
  int              w_idx;

  // Scan from the highest offset down so the requester closest to r_rr_ptr wins.
  always_comb begin
    w_pick_oh = '0;
    w_idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if ((req_valid & (NREQ'(1) << w_idx)) != '0) w_pick_oh = NREQ'(1) << w_idx;
    end
  end

  always_comb begin
    wdata     = '0;
    w_ptr_inc = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) begin
        wdata     = req_data[i*DSIZE +: DSIZE];
        w_ptr_inc = PW'((i + 1) % NREQ);
      end
    end
  end

  assign busy      = (r_state == S_LOCK);
  assign grant     = r_grant;
  assign req_ready = (busy && !wfull) ? r_grant : '0;
  assign winc      = busy && !wfull && ((req_valid & r_grant) != '0);
  assign w_release = ((req_last & r_grant) != '0) || (r_beat_cnt == 8'(MAX_BURST - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (req_valid != '0) begin
          w_state_nxt    = S_LOCK;
          w_grant_nxt    = w_pick_oh;
          w_beat_cnt_nxt = '0;
        end
      end
      S_LOCK: begin
        if (winc) begin
          if (w_release) begin
            w_state_nxt    = S_IDLE;
            w_grant_nxt    = '0;
            w_rr_ptr_nxt   = w_ptr_inc;
            w_beat_cnt_nxt = '0;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 8'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

endmodule
